mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly after the execute stage. It consumes the `core::ex_mem_t` register, computes load/store effective addresses, runs a request/acknowledge transaction on the data-memory port, and performs byte-lane steering and sign/zero extension. It registers the result into `core::mem_wb_t` for write-back. Non-memory instructions pass through in one cycle; memory instructions stall the upstream pipeline until the bus acknowledges.

---
 rtl/mem_stage_pkg.sv | 60 ++++++
 rtl/mem_lane.sv | 54 +++++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: pipeline registers, decode fields,
// load/store encodings and the stage FSM state type.
package mem_stage_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] reg_t;
    typedef logic        bool_t;

    localparam logic [6:0] opcode_load   = 7'b0000011;
    localparam logic [6:0] opcode_store  = 7'b0100011;
    localparam logic [6:0] opcode_op_imm = 7'b0010011;

    localparam logic [2:0] f3_lb  = 3'b000;
    localparam logic [2:0] f3_lh  = 3'b001;
    localparam logic [2:0] f3_lw  = 3'b010;
    localparam logic [2:0] f3_lbu = 3'b100;
    localparam logic [2:0] f3_lhu = 3'b101;
    localparam logic [2:0] f3_sb  = 3'b000;
    localparam logic [2:0] f3_sh  = 3'b001;
    localparam logic [2:0] f3_sw  = 3'b010;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        reg_t       imm;
    } de_inst_t;

    typedef struct packed {
        addr_t    pc;
        reg_t     inst;
        de_inst_t de_inst;
        reg_t     rs1_value;
        reg_t     rs2_value;
        reg_t     ex_result;
        addr_t    ex_addr;
        logic     valid;
    } ex_mem_t;

    typedef struct packed {
        addr_t    pc;
        reg_t     inst;
        de_inst_t de_inst;
        addr_t    ex_addr;
        reg_t     wb_value;
        logic     fault;
        logic     valid;
    } mem_wb_t;

    localparam mem_wb_t mem_wb_rst = '0;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for the data port: store replication and byte enables,
// load extraction with sign/zero extension, and the misalignment flag.
module mem_lane
    import mem_stage_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] ea_lo,
    input  logic       store,
    input  reg_t       rs2,
    input  reg_t       rdata,
    output reg_t       wdata,
    output logic [3:0] be,
    output reg_t       load_value,
    output logic       misalign
);

    reg_t        shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        shifted  = rdata >> {ea_lo, 3'b000};
        sel_byte = shifted[7:0];
        sel_half = ea_lo[1] ? rdata[31:16] : rdata[15:0];

        wdata      = rs2;
        be         = 4'hF;
        load_value = rdata;
        misalign   = 1'b0;

        // funct3[2] distinguishes unsigned loads; funct3[1:0] is the access size
        case (funct3[1:0])
            2'b00: begin
                if (store) begin
                    wdata = {4{rs2[7:0]}};
                    be    = 4'b0001 << ea_lo;
                end
                load_value = funct3[2] ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            2'b01: begin
                misalign = ea_lo[0];
                if (store) begin
                    wdata = {2{rs2[15:0]}};
                    be    = 4'b0011 << {ea_lo[1], 1'b0};
                end
                load_value = funct3[2] ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            default: begin
                misalign = (ea_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: effective address, req/ack data-port transaction,
// lane steering and the mem_wb register. Memory ops stall upstream until DONE.
//
// state      | meaning
// MEM_IDLE   | pass-through; launches an aligned, enabled memory op
// MEM_ACCESS | dmem_req held with stable bus outputs, waiting for dmem_ack
// MEM_DONE   | read data latched; retires into mem_wb once next_rdy is high
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        next_rdy,
    input  ex_mem_t     ex_mem,
    output mem_wb_t     mem_wb,
    output logic        rdy,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    mem_state_t state;
    addr_t      ea;
    logic       is_load, is_store, is_mem, start;
    logic [2:0] acc_f3, lane_f3;
    logic [1:0] acc_ea_lo, lane_ea_lo;
    reg_t       rdata_q, lane_wdata, lane_load;
    logic [3:0] lane_be;
    logic       misalign;
    mem_wb_t    pass_wb, done_wb;

    assign ea       = ex_mem.rs1_value + ex_mem.de_inst.imm;
    assign is_load  = ex_mem.valid && (ex_mem.de_inst.opcode == opcode_load);
    assign is_store = ex_mem.valid && (ex_mem.de_inst.opcode == opcode_store);
    assign is_mem   = is_load || is_store;
    assign start    = is_mem && en && !misalign;

    // Extension in DONE must use the launched access, not whatever sits upstream.
    assign lane_f3    = (state == MEM_IDLE) ? ex_mem.de_inst.funct3 : acc_f3;
    assign lane_ea_lo = (state == MEM_IDLE) ? ea[1:0] : acc_ea_lo;

    mem_lane u_lane (
        .funct3     (lane_f3),
        .ea_lo      (lane_ea_lo),
        .store      (is_store),
        .rs2        (ex_mem.rs2_value),
        .rdata      (rdata_q),
        .wdata      (lane_wdata),
        .be         (lane_be),
        .load_value (lane_load),
        .misalign   (misalign)
    );

    always_comb begin
        pass_wb          = mem_wb_rst;
        pass_wb.pc       = ex_mem.pc;
        pass_wb.inst     = ex_mem.inst;
        pass_wb.de_inst  = ex_mem.de_inst;
        pass_wb.ex_addr  = ex_mem.ex_addr;
        pass_wb.valid    = en && ex_mem.valid;
        done_wb          = pass_wb;
        pass_wb.wb_value = is_mem ? '0 : ex_mem.ex_result;
        pass_wb.fault    = is_mem && misalign;
        done_wb.wb_value = dmem_we ? '0 : lane_load;
    end

    always_comb begin
        rdy = 1'b0;
        case (state)
            MEM_IDLE:   rdy = !start && en && next_rdy;
            MEM_ACCESS: rdy = 1'b0;
            MEM_DONE:   rdy = next_rdy;
            default:    rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MEM_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            mem_wb     <= mem_wb_rst;
            acc_f3     <= '0;
            acc_ea_lo  <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {ea[31:2], 2'b00};
                        dmem_wdata <= lane_wdata;
                        dmem_be    <= lane_be;
                        acc_f3     <= ex_mem.de_inst.funct3;
                        acc_ea_lo  <= ea[1:0];
                        state      <= MEM_ACCESS;
                        if (next_rdy) mem_wb <= mem_wb_rst;
                    end else if (next_rdy) begin
                        mem_wb <= pass_wb;
                    end
                end
                MEM_ACCESS: begin
                    if (next_rdy) mem_wb <= mem_wb_rst;
                    if (dmem_ack) begin
                        rdata_q  <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    if (next_rdy) begin
                        mem_wb <= done_wb;
                        state  <= MEM_IDLE;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected retirements.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, next_rdy, rdy;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wb;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   retired = 0;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .next_rdy   (next_rdy),
        .ex_mem     (ex_mem),
        .mem_wb     (mem_wb),
        .rdy        (rdy),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ex_mem_t mk(input logic [31:0] pc, input logic [6:0] opc,
                                   input logic [2:0] f3, input logic [31:0] rs1v,
                                   input logic [31:0] imm, input logic [31:0] rs2v,
                                   input logic [31:0] res);
        ex_mem_t m;
        m = '0;
        m.pc = pc;
        m.de_inst.opcode = opc;
        m.de_inst.funct3 = f3;
        m.de_inst.imm = imm;
        m.rs1_value = rs1v;
        m.rs2_value = rs2v;
        m.ex_result = res;
        m.valid = 1'b1;
        return m;
    endfunction

    task automatic expect_wb(input logic [31:0] pc, input logic [31:0] wb, input logic fault);
        exp_t e;
        e.pc = pc;
        e.wb = wb;
        e.fault = fault;
        sb_q.push_back(e);
    endtask

    // One clock; ack is a single-cycle pulse; retirements are popped and compared.
    task automatic tick();
        logic nr;
        exp_t e;
        nr = next_rdy;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        if (nr && mem_wb.valid === 1'b1) begin
            retired++;
            check("sb_occupancy", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("wb_pc", mem_wb.pc, e.pc);
                check("wb_value", mem_wb.wb_value, e.wb);
                check("wb_fault", 32'(mem_wb.fault), 32'(e.fault));
            end
        end
    endtask

    task automatic wait_retire(input int max, output int n);
        int r0;
        r0 = retired;
        n = 0;
        while (retired == r0 && n < max) begin
            tick();
            n++;
        end
        check("retire_timeout", 32'(retired != r0), 32'd1);
    endtask

    function automatic ex_mem_t idle_op();
        ex_mem_t m;
        m = '0;
        return m;
    endfunction

    initial begin
        int n, r0;
        rst = 1'b1; en = 1'b0; next_rdy = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        ex_mem = idle_op();
        tick(); tick();
        check("rst_valid", 32'(mem_wb.valid), 32'd0);
        check("rst_fault", 32'(mem_wb.fault), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_rdy_en0", 32'(rdy), 32'd0);
        rst = 1'b0; en = 1'b1;

        // addi pass-through
        ex_mem = mk(32'h100, opcode_op_imm, 3'b000, 32'h0, 32'h10, 32'h0, 32'h10);
        expect_wb(32'h100, 32'h10, 1'b0);
        #1 check("addi_rdy", 32'(rdy), 32'd1);
        r0 = retired;
        tick();
        check("addi_retired", 32'(retired - r0), 32'd1);
        check("addi_no_req", 32'(dmem_req), 32'd0);

        // two back-to-back ALU ops, one per cycle
        ex_mem = mk(32'h120, opcode_op_imm, 3'b000, 32'h0, 32'h0, 32'h0, 32'h1);
        expect_wb(32'h120, 32'h1, 1'b0);
        r0 = retired;
        tick();
        ex_mem = mk(32'h124, opcode_op_imm, 3'b000, 32'h0, 32'h0, 32'h0, 32'h2);
        expect_wb(32'h124, 32'h2, 1'b0);
        tick();
        check("b2b_retired", 32'(retired - r0), 32'd2);

        // sb, ack in first request cycle
        ex_mem = mk(32'h104, opcode_store, f3_sb, 32'h1000, 32'd3, 32'hA5, 32'h0);
        expect_wb(32'h104, 32'h0, 1'b0);
        #1 check("sb_rdy_idle", 32'(rdy), 32'd0);
        tick();
        check("sb_req", 32'(dmem_req), 32'd1);
        check("sb_addr", dmem_addr, 32'h1000);
        check("sb_be", 32'(dmem_be), 32'b1000);
        check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        check("sb_we", 32'(dmem_we), 32'd1);
        check("sb_rdy_access", 32'(rdy), 32'd0);
        check("sb_bubble", 32'(mem_wb.valid), 32'd0);
        dmem_ack = 1'b1;
        tick();
        check("sb_req_drop", 32'(dmem_req), 32'd0);
        check("sb_rdy_done", 32'(rdy), 32'd1);
        wait_retire(4, n);
        check("sb_done_latency", n, 32'd1);
        ex_mem = idle_op();

        // lb at 0x2001, ack on the fourth request cycle
        ex_mem = mk(32'h108, opcode_load, f3_lb, 32'h2000, 32'd1, 32'h0, 32'h0);
        expect_wb(32'h108, 32'hFFFFFF80, 1'b0);
        tick();
        check("lb_be", 32'(dmem_be), 32'hF);
        check("lb_we", 32'(dmem_we), 32'd0);
        check("lb_addr", dmem_addr, 32'h2000);
        tick(); tick(); tick();
        check("lb_bubble", 32'(mem_wb.valid), 32'd0);
        check("lb_req_hold", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h0000_8000;
        wait_retire(8, n);
        check("lb_latency", 32'(4 + n), 32'd6);
        ex_mem = idle_op();

        // lhu at 0x3002, ack in first cycle
        ex_mem = mk(32'h10C, opcode_load, f3_lhu, 32'h3000, 32'd2, 32'h0, 32'h0);
        expect_wb(32'h10C, 32'h0000BEEF, 1'b0);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hBEEF_0000;
        wait_retire(8, n);
        check("lhu_latency", 32'(1 + n), 32'd3);
        ex_mem = idle_op();

        // misaligned lw and sh fault in one cycle without a request
        ex_mem = mk(32'h110, opcode_load, f3_lw, 32'h3000, 32'd2, 32'h0, 32'h0);
        expect_wb(32'h110, 32'h0, 1'b1);
        #1 check("lw_mis_rdy", 32'(rdy), 32'd1);
        r0 = retired;
        tick();
        check("lw_mis_retired", 32'(retired - r0), 32'd1);
        check("lw_mis_no_req", 32'(dmem_req), 32'd0);
        ex_mem = mk(32'h128, opcode_store, f3_sh, 32'h10, 32'd1, 32'h1234, 32'h0);
        expect_wb(32'h128, 32'h0, 1'b1);
        tick();
        check("sh_mis_no_req", 32'(dmem_req), 32'd0);

        // aligned sh to the upper half
        ex_mem = mk(32'h130, opcode_store, f3_sh, 32'h40, 32'd2, 32'hFFFF1234, 32'h0);
        expect_wb(32'h130, 32'h0, 1'b0);
        tick();
        check("sh_be", 32'(dmem_be), 32'b1100);
        check("sh_wdata", dmem_wdata, 32'h12341234);
        dmem_ack = 1'b1;
        wait_retire(8, n);
        ex_mem = idle_op();

        // flushed memory op does not reach the bus
        en = 1'b0;
        ex_mem = mk(32'h200, opcode_load, f3_lw, 32'h4000, 32'd0, 32'h0, 32'h0);
        #1 check("flush_rdy", 32'(rdy), 32'd0);
        tick();
        check("flush_no_req", 32'(dmem_req), 32'd0);
        check("flush_invalid", 32'(mem_wb.valid), 32'd0);
        en = 1'b1;
        ex_mem = idle_op();

        // reset mid-ACCESS, then a late ack
        ex_mem = mk(32'h114, opcode_load, f3_lw, 32'h4000, 32'd0, 32'h0, 32'h0);
        tick();
        check("rstacc_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        ex_mem = idle_op();
        tick();
        rst = 1'b0;
        check("rstacc_req_drop", 32'(dmem_req), 32'd0);
        check("rstacc_valid", 32'(mem_wb.valid), 32'd0);
        #1 check("rstacc_rdy_idle", 32'(rdy), 32'd1);
        r0 = retired;
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        tick();
        tick();
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("late_ack_no_retire", 32'(retired - r0), 32'd0);

        // lbu held in DONE by next_rdy=0
        ex_mem = mk(32'h118, opcode_load, f3_lbu, 32'h5000, 32'd3, 32'h0, 32'h0);
        expect_wb(32'h118, 32'h0000009C, 1'b0);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h9C00_0000;
        tick();
        next_rdy = 1'b0;
        #1 check("hold_rdy0", 32'(rdy), 32'd0);
        tick();
        check("hold_valid0", 32'(mem_wb.valid), 32'd0);
        check("hold_rdy1", 32'(rdy), 32'd0);
        tick();
        check("hold_valid1", 32'(mem_wb.valid), 32'd0);
        check("hold_pc", mem_wb.pc, 32'h0);
        next_rdy = 1'b1;
        #1 check("hold_release_rdy", 32'(rdy), 32'd1);
        wait_retire(4, n);
        check("hold_release_latency", n, 32'd1);
        ex_mem = idle_op();
        tick();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
